net_rx: RTL and testbench
=========================

Name: net_rx

Overview:
- Ejection-side receiver attached to one network output port (oN of net).
- Takes the 10-bit flit stream leaving the network and checks the framing.
- Buffers complete packets and hands them to the local host over a valid/ready interface.
- Only whole, well-formed packets become visible to the host. Malformed, oversized, misrouted or overflowing packets are discarded and counted.

Parameters:
- NODE_ID, 0: 2-bit node number of this port; used by the destination check.
- DEPTH, 16: flit buffer entries; power of two, minimum 4.
- MAXLEN, 8: maximum packet length in flits, head and tail included; minimum 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset: one clock; synchronous, active-high (asserted = 1, the `ASSERT level from sw.vh).
- in_flit  in  10 ([`PKTW:0])  flit from the network output; no backpressure.
- out_flit  out  10  flit at the buffer head; type bits preserved.
- out_valid  out  1  out_flit holds a flit of a committed packet.
- out_ready  in  1  host consumes out_flit when out_valid && out_ready.
- pkt_cnt  out  8  committed packets, wraps at 255->0.
- err_cnt  out  8  discarded packets/flits, saturates at 255.
- ovf  out  1  one-cycle pulse when a packet is dropped for lack of space.

Behaviour:
- Flit format: bits [9:8] are the type; 00 idle, 10 head, 01 body, 11 tail. Bits [7:0] are data.
- Head data [1:0] is the destination node. Minimum packet is head+tail.
- Buffer pointers: wr_ptr (speculative), cmt_ptr (committed), rd_ptr; each log2(DEPTH)+1 bits.
- Full: wr_ptr-rd_ptr == DEPTH.
- out_valid = (rd_ptr != cmt_ptr); out_flit = mem[rd_ptr].
- Reset: state IDLE, all pointers 0, len 0, out_valid 0, pkt_cnt 0, err_cnt 0, ovf 0.
- Reset mid-packet: the partial packet is lost. Uncommitted data is never exposed.
- Idle flits (type 00) are ignored in every state and do not count toward length.
- FSM states:
  - IDLE:
    - head -> write, len=1, go to PKT.
    - body/tail -> discard, err_cnt+1, stay IDLE.
  - PKT:
    - body -> write, len+1.
    - tail -> write, cmt_ptr<=wr_ptr+1, pkt_cnt+1, go to IDLE.
    - head -> wr_ptr<=cmt_ptr (abort current packet), err_cnt+1, then treat the flit as a new head (write, len=1, stay PKT).
  - DROP:
    - discard all flits until tail; on tail go to IDLE. No counter change in DROP.
- Length overflow: a non-tail flit arriving when len == MAXLEN-1 gives wr_ptr<=cmt_ptr, err_cnt+1, go to DROP.
- Space overflow: any flit to be written while full gives wr_ptr<=cmt_ptr, err_cnt+1, ovf=1 for one cycle.
  - Go to DROP, or to IDLE if the flit was a tail.
  - A full buffer on a head in IDLE is the same case.
- Latency: tail sampled at edge N -> out_valid=1 after edge N (head flit presented). The host reads one flit per cycle while out_ready=1.
- Simultaneous commit and read in the same cycle: both take effect.
- Full is evaluated with the rd_ptr value from before the edge. A read in the same cycle does not free space for the incoming flit.
- Host back-pressure never affects the network side; only the buffer fills.

Optional Feature:
- Macro: NET_RX_DSTCHK_EN.
- Defined: a head with data[1:0] != NODE_ID is discarded, err_cnt+1, go to DROP; the rest of that packet is discarded.
- Undefined: the destination is not checked; every well-framed packet is accepted.

Test Plan:
- Packet delivery: after reset, drive 10_1001_0000, 01_1001_0000, 01_1001_0001, 11_1001_0010 with NODE_ID=0 and out_ready=1 -> out_valid rises the cycle after the tail; the 4 flits appear in order unchanged; pkt_cnt=1.
- Orphan flits: body 01_0000_0001 then tail 11_0000_0010 in IDLE -> no output, err_cnt=2.
- Head abort: head 10_0000_0000, body, head 10_0000_0100, body, tail -> only the second 3-flit packet is output; err_cnt=1, pkt_cnt=1.
- Length overflow: MAXLEN=8, head followed by 9 bodies and a tail -> no output, err_cnt=1. A following 4-flit packet is delivered normally.
- Buffer overflow: out_ready=0, DEPTH=16, five 4-flit packets -> the first four are committed; the fifth head gives ovf pulse, err_cnt=1. Then out_ready=1 -> exactly 16 flits drain.
- Destination check: with NET_RX_DSTCHK_EN, NODE_ID=0, head 10_1001_0010 -> packet dropped, err_cnt=1. Without the macro -> same packet delivered, pkt_cnt=1. Mid-packet rst=1 for one cycle -> out_valid=0 and counters 0 on the next cycle.

Source files
------------

// File: rtl/net_rx.sv
// net_rx: ejection-side packet receiver with framing checks and a commit
// buffer, so the host only ever sees whole, well-formed packets.
// Ports: clk, rst (sync, active-high), in_flit[9:0] (from network),
//   out_flit[9:0]/out_valid/out_ready (host handshake), pkt_cnt[7:0]
//   (committed packets, wraps), err_cnt[7:0] (discards, saturates),
//   ovf (one-cycle pulse on a space-overflow drop).
// Optional: `define NET_RX_DSTCHK_EN to drop heads addressed elsewhere.
module net_rx #(
  parameter int NODE_ID = 0,
  parameter int DEPTH   = 16,
  parameter int MAXLEN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in_flit,
  output logic [9:0] out_flit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pkt_cnt,
  output logic [7:0] err_cnt,
  output logic       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(MAXLEN + 1);

  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] cmt_q, cmt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    pkt_q, pkt_d;
  logic [7:0]    err_q, err_d;
  logic          ovf_q, ovf_d;

  logic [9:0]    mem [DEPTH];
  logic          we;
  logic [PW-1:0] waddr;
  logic [1:0]    err_inc;
  logic [8:0]    err_sum;
  logic          new_head;
  logic          full_wr;
  logic          full_cmt;
  logic          dst_bad;
  logic          rd_en;
  logic [1:0]    ftype;

  localparam logic [1:0] NID = NODE_ID[1:0];

  assign ftype = in_flit[9:8];

`ifdef NET_RX_DSTCHK_EN
  assign dst_bad = (in_flit[1:0] != NID);
`else
  assign dst_bad = 1'b0 && (in_flit[1:0] != NID);
`endif

  // Fullness uses the pre-edge read pointer: a same-cycle read
  // does not make room for the incoming flit.
  assign full_wr  = ((wr_q - rd_q) == PW'(DEPTH));
  // A head always restarts at the commit pointer.
  assign full_cmt = ((cmt_q - rd_q) == PW'(DEPTH));

  assign out_valid = (rd_q != cmt_q);
  assign out_flit  = mem[rd_q[AW-1:0]];
  assign rd_en     = out_valid && out_ready;
  assign pkt_cnt   = pkt_q;
  assign err_cnt   = err_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    cmt_d    = cmt_q;
    len_d    = len_q;
    pkt_d    = pkt_q;
    ovf_d    = 1'b0;
    we       = 1'b0;
    waddr    = wr_q;
    err_inc  = 2'd0;
    new_head = 1'b0;
    rd_d     = rd_q + PW'(rd_en);

    unique case (state_q)
      IDLE: begin
        if (ftype == T_HEAD) begin
          new_head = 1'b1;
        end else if (ftype != 2'b00) begin
          err_inc = 2'd1;
        end
      end
      PKT: begin
        unique case (ftype)
          T_HEAD: begin
            // Abort the open packet, then restart on this head.
            err_inc  = 2'd1;
            wr_d     = cmt_q;
            new_head = 1'b1;
          end
          T_BODY: begin
            if (len_q == LW'(MAXLEN - 1)) begin
              err_inc = 2'd1;
              wr_d    = cmt_q;
              len_d   = '0;
              state_d = DROP;
            end else if (full_wr) begin
              err_inc = 2'd1;
              ovf_d   = 1'b1;
              wr_d    = cmt_q;
              len_d   = '0;
              state_d = DROP;
            end else begin
              we    = 1'b1;
              wr_d  = wr_q + PW'(1);
              len_d = len_q + LW'(1);
            end
          end
          T_TAIL: begin
            len_d   = '0;
            state_d = IDLE;
            if (full_wr) begin
              err_inc = 2'd1;
              ovf_d   = 1'b1;
              wr_d    = cmt_q;
            end else begin
              we    = 1'b1;
              wr_d  = wr_q + PW'(1);
              cmt_d = wr_q + PW'(1);
              pkt_d = pkt_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
      DROP: begin
        if (ftype == T_TAIL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (new_head) begin
      if (dst_bad) begin
        err_inc = err_inc + 2'd1;
        wr_d    = cmt_q;
        len_d   = '0;
        state_d = DROP;
      end else if (full_cmt) begin
        err_inc = err_inc + 2'd1;
        ovf_d   = 1'b1;
        wr_d    = cmt_q;
        len_d   = '0;
        state_d = DROP;
      end else begin
        we      = 1'b1;
        waddr   = cmt_q;
        wr_d    = cmt_q + PW'(1);
        len_d   = LW'(1);
        state_d = PKT;
      end
    end

    err_sum = {1'b0, err_q} + {7'd0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      cmt_q   <= '0;
      rd_q    <= '0;
      len_q   <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cmt_q   <= cmt_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW-1:0]] <= in_flit;
  end

endmodule

// File: tb/tb_net_rx.sv
// tb_net_rx: directed self-checking bench for net_rx
// (NODE_ID=0, DEPTH=16, MAXLEN=8).
module tb_net_rx;

  logic       clk;
  logic       rst;
  logic [9:0] in_flit;
  logic [9:0] out_flit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pkt_cnt;
  logic [7:0] err_cnt;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q [$];

  net_rx #(.NODE_ID(0), .DEPTH(16), .MAXLEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] f);
    in_flit = f;
    tick();
    in_flit = 10'h000;
  endtask

  task automatic send_exp(input logic [9:0] f);
    exp_q.push_back(f);
    send(f);
  endtask

  // Drain n flits against the expectation queue, then expect empty.
  task automatic drain(input string tag, input int n);
    logic [9:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
      chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_flit"}, {22'd0, out_flit}, {22'd0, e});
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_flit   = 10'h000;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_pkt", {24'd0, pkt_cnt}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    // Basic delivery with host ready throughout
    out_ready = 1'b1;
    send_exp(10'h290);
    send_exp(10'h190);
    send_exp(10'h191);
    chk("lat_pre", {31'd0, out_valid}, 32'd0);
    send_exp(10'h392);
    chk("lat_post", {31'd0, out_valid}, 32'd1);
    drain("pkt1", 4);
    chk("pkt1_cnt", {24'd0, pkt_cnt}, 32'd1);

    // Orphan body and tail in IDLE
    send(10'h101);
    send(10'h302);
    chk("orph_vld", {31'd0, out_valid}, 32'd0);
    chk("orph_err", {24'd0, err_cnt}, 32'd2);

    // Head abort: only the second packet survives
    send(10'h200);
    send(10'h111);
    send_exp(10'h204);
    send_exp(10'h112);
    send_exp(10'h313);
    chk("abrt_err", {24'd0, err_cnt}, 32'd3);
    chk("abrt_pkt", {24'd0, pkt_cnt}, 32'd2);
    drain("abrt", 3);

    // Length overflow: head + 9 bodies + tail dropped
    send(10'h220);
    for (int i = 0; i < 9; i++) send(10'h120 | 10'(i));
    send(10'h32F);
    chk("len_vld", {31'd0, out_valid}, 32'd0);
    chk("len_err", {24'd0, err_cnt}, 32'd4);
    send_exp(10'h230);
    send_exp(10'h131);
    send_exp(10'h132);
    send_exp(10'h333);
    chk("len_pkt", {24'd0, pkt_cnt}, 32'd3);
    drain("len", 4);

    // Buffer overflow: four packets fill 16 entries, fifth dropped
    for (int p = 0; p < 4; p++) begin
      send_exp(10'h200 | 10'(p << 4));
      send_exp(10'h101 | 10'(p << 4));
      send_exp(10'h102 | 10'(p << 4));
      send_exp(10'h303 | 10'(p << 4));
    end
    chk("full_pkt", {24'd0, pkt_cnt}, 32'd7);
    chk("full_ovf0", {31'd0, ovf}, 32'd0);
    send(10'h240);
    chk("full_ovf1", {31'd0, ovf}, 32'd1);
    chk("full_err", {24'd0, err_cnt}, 32'd5);
    send(10'h141);
    chk("full_ovf2", {31'd0, ovf}, 32'd0);
    send(10'h142);
    send(10'h343);
    chk("full_pkt2", {24'd0, pkt_cnt}, 32'd7);
    drain("full", 16);

    // Destination check
`ifdef NET_RX_DSTCHK_EN
    send(10'h292);
    send(10'h101);
    send(10'h302);
    chk("dst_err", {24'd0, err_cnt}, 32'd6);
    chk("dst_pkt", {24'd0, pkt_cnt}, 32'd7);
    chk("dst_vld", {31'd0, out_valid}, 32'd0);
`else
    send_exp(10'h292);
    send_exp(10'h101);
    send_exp(10'h302);
    chk("dst_err", {24'd0, err_cnt}, 32'd5);
    chk("dst_pkt", {24'd0, pkt_cnt}, 32'd8);
    drain("dst", 3);
`endif

    // Mid-packet reset
    send(10'h200);
    send(10'h101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_vld", {31'd0, out_valid}, 32'd0);
    chk("mrst_pkt", {24'd0, pkt_cnt}, 32'd0);
    chk("mrst_err", {24'd0, err_cnt}, 32'd0);
    send(10'h302);
    chk("mrst_tail_vld", {31'd0, out_valid}, 32'd0);
    chk("mrst_tail_err", {24'd0, err_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
